// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: sample/result bundle for the Johnson-code decoder.
//   master : drives in_valid/in, observes the decoded results
//   slave  : the decoder itself
//   in_valid, in       - sample strobe and WIDTH-bit Johnson code
//   index, up_down     - last legal index, direction of last adjacent step
//   locked             - decoder is tracking a legal code
//   step, code_err,
//   step_err           - one-cycle event pulses
//   position           - signed net step count (POS_W bits, wraps)
interface johnson_decoder_if #(
    parameter int WIDTH = 3,
    parameter int IDX_W = 3,
    parameter int POS_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic [IDX_W-1:0] index;
    logic             up_down;
    logic             locked;
    logic             step;
    logic             code_err;
    logic             step_err;
    logic [POS_W-1:0] position;

    modport master (
        output in_valid, in,
        input  index, up_down, locked, step, code_err, step_err, position
    );

    modport slave (
        input  in_valid, in,
        output index, up_down, locked, step, code_err, step_err, position
    );
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a WIDTH-bit Johnson code into a binary index,
// infers count direction from successive legal codes, flags illegal codes
// and non-adjacent jumps, and keeps a wrapping signed net-step position.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - johnson_decoder_if.slave (sample in, registered results out)
// All outputs are registered: a sample taken on edge N shows after edge N.
module johnson_decoder #(
    parameter int WIDTH = 3,
    parameter int IDX_W = 3,
    parameter int POS_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    johnson_decoder_if.slave   bus
);
    localparam int               NSTATES = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NSTATES - 1);

    typedef enum logic [1:0] {UNLOCKED, LOCKED, ERROR} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             up_down_q, up_down_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             cerr_q, cerr_d;
    logic             serr_q, serr_d;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_legal;
    logic [IDX_W-1:0] idx_up, idx_dn;

    // Index k < WIDTH has its low k bits set; index k >= WIDTH has its
    // low (k-WIDTH) bits clear and the rest set.
    function automatic logic [WIDTH-1:0] johnson_code(input int k);
        logic [WIDTH-1:0] c;
        for (int b = 0; b < WIDTH; b++)
            c[b] = (k < WIDTH) ? (b < k) : (b >= k - WIDTH);
        return c;
    endfunction

    always_comb begin
        dec_idx   = '0;
        dec_legal = 1'b0;
        for (int k = 0; k < NSTATES; k++) begin
            if (bus.in == johnson_code(k)) begin
                dec_idx   = IDX_W'(k);
                dec_legal = 1'b1;
            end
        end
    end

    // Neighbours of the held index, modulo 2*WIDTH.
    assign idx_up = (index_q == LAST) ? '0 : index_q + 1'b1;
    assign idx_dn = (index_q == '0) ? LAST : index_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        up_down_d = up_down_q;
        pos_d     = pos_q;
        step_d    = 1'b0;
        cerr_d    = 1'b0;
        serr_d    = 1'b0;
        if (bus.in_valid) begin
            if (!dec_legal) begin
                // Illegal code from any state: index keeps last legal value.
                cerr_d  = 1'b1;
                state_d = ERROR;
            end else if (state_q != LOCKED) begin
                // (Re)acquire without a step.
                index_d = dec_idx;
                state_d = LOCKED;
            end else if (dec_idx == index_q) begin
                // Stall: nothing changes.
            end else if (dec_idx == idx_up) begin
                step_d    = 1'b1;
                up_down_d = 1'b0;
                pos_d     = pos_q + POS_W'(1);
                index_d   = dec_idx;
            end else if (dec_idx == idx_dn) begin
                step_d    = 1'b1;
                up_down_d = 1'b1;
                pos_d     = pos_q - POS_W'(1);
                index_d   = dec_idx;
            end else begin
                serr_d  = 1'b1;
                index_d = dec_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= UNLOCKED;
            index_q   <= '0;
            up_down_q <= 1'b0;
            pos_q     <= '0;
            step_q    <= 1'b0;
            cerr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            up_down_q <= up_down_d;
            pos_q     <= pos_d;
            step_q    <= step_d;
            cerr_q    <= cerr_d;
            serr_q    <= serr_d;
        end
    end

    assign bus.index    = index_q;
    assign bus.up_down  = up_down_q;
    assign bus.locked   = (state_q == LOCKED);
    assign bus.step     = step_q;
    assign bus.code_err = cerr_q;
    assign bus.step_err = serr_q;
    assign bus.position = pos_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed test of johnson_decoder (WIDTH=3) with
// hand-computed expectations checked by immediate assertions.
module tb_johnson_decoder;
    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    johnson_decoder_if #(.WIDTH(3), .IDX_W(3), .POS_W(16)) jif ();

    johnson_decoder #(.WIDTH(3), .IDX_W(3), .POS_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (jif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample, clock it in, land 1 time unit after the edge.
    task automatic sample(input logic v, input logic [2:0] code);
        jif.in_valid = v;
        jif.in       = code;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] idx, input logic ud,
                           input logic lk, input logic st, input logic ce,
                           input logic se, input logic [15:0] pos);
        check({tag, ".index"},    32'(jif.index),    32'(idx));
        check({tag, ".up_down"},  32'(jif.up_down),  32'(ud));
        check({tag, ".locked"},   32'(jif.locked),   32'(lk));
        check({tag, ".step"},     32'(jif.step),     32'(st));
        check({tag, ".code_err"}, 32'(jif.code_err), 32'(ce));
        check({tag, ".step_err"}, 32'(jif.step_err), 32'(se));
        check({tag, ".position"}, 32'(jif.position), 32'(pos));
    endtask

    logic [2:0] codes [6];
    int         idx;

    initial begin
        codes = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
        reset        = 1'b0;
        jif.in_valid = 1'b0;
        jif.in       = 3'b000;

        // Reset state (valid samples during reset are ignored).
        jif.in_valid = 1'b1;
        jif.in       = 3'b011;
        repeat (2) @(posedge clock);
        #1;
        chk_all("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        jif.in_valid = 1'b0;
        reset        = 1'b1;

        // Idle while unlocked: stays unlocked.
        sample(1'b0, 3'b011);
        chk_all("idle_unl", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // First valid sample only locks.
        sample(1'b1, 3'b000);
        chk_all("lock", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Up count with wrap: 001 011 111 110 100 000.
        for (int i = 1; i <= 6; i++) begin
            sample(1'b1, codes[i % 6]);
            chk_all($sformatf("up%0d", i), 3'(i % 6), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'(i));
        end

        // Direction reversal: 100, 110.
        sample(1'b1, 3'b100);
        chk_all("dn5", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        sample(1'b1, 3'b110);
        chk_all("dn4", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);
        sample(1'b1, 3'b111);
        chk_all("dn3", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3);
        sample(1'b1, 3'b011);
        chk_all("dn2", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2);

        // Illegal codes and recovery.
        sample(1'b1, 3'b010);
        chk_all("ill010", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        sample(1'b1, 3'b101);
        chk_all("ill101", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        sample(1'b1, 3'b111);
        chk_all("recov", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

        // Walk down to 000 (position goes negative).
        sample(1'b1, 3'b011);
        sample(1'b1, 3'b001);
        sample(1'b1, 3'b000);
        chk_all("neg", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);

        // Non-adjacent jump 0 -> 3.
        sample(1'b1, 3'b111);
        chk_all("jump", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        // Stall on the same code.
        sample(1'b1, 3'b111);
        chk_all("stall", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        // Idle with a code on the bus that would otherwise be an error.
        for (int i = 0; i < 3; i++) begin
            sample(1'b0, 3'b010);
            chk_all($sformatf("idle%0d", i), 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        end

        // Step up 0x8000 times: 0xFFFF -> 0x7FFF.
        idx = 3;
        for (int i = 0; i < 32768; i++) begin
            idx = (idx + 1) % 6;
            sample(1'b1, codes[idx]);
        end
        chk_all("pos7fff", 3'(idx), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF);
        idx = (idx + 1) % 6;
        sample(1'b1, codes[idx]);
        chk_all("pos8000", 3'(idx), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2;
        reset = 1'b0;
        #1;
        chk_all("async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        jif.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the up/down Johnson counter. Samples a WIDTH-bit Johnson code each valid cycle, decodes it to a binary index, and infers the count direction from successive codes. Flags illegal codes and non-adjacent jumps, and keeps a signed net-step position. It sits downstream of a Johnson counter, or of any Johnson-coded link, and feeds the monitoring and control logic.

## Interface
- WIDTH, 3: Johnson code width; the code has 2*WIDTH legal states.
- IDX_W, 3: index width; must satisfy 2^IDX_W >= 2*WIDTH.
- POS_W, 16: width of the signed position accumulator.

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample `in` this cycle.
- in  in  WIDTH  Johnson code.
- index  out  IDX_W  decoded index of the last accepted legal code.
- up_down  out  1  direction of the last adjacent step: 0 = up (index+1), 1 = down (index−1).
- locked  out  1  decoder is tracking a legal code.
- step  out  1  one-cycle pulse on each adjacent step.
- code_err  out  1  one-cycle pulse when an illegal code is sampled.
- step_err  out  1  one-cycle pulse when a legal but non-adjacent code is sampled.
- position  out  POS_W  signed net step count.

## Operation
- **Code map.** Index k for k < WIDTH has bits [k−1:0] = 1 and the rest 0. Index k for k >= WIDTH has bits [k−WIDTH−1:0] = 0 and the rest 1.
  - WIDTH = 3 gives 0:000, 1:001, 2:011, 3:111, 4:110, 5:100.
  - Every other pattern is illegal (for WIDTH = 3: 010 and 101).
- **Adjacency.** Indices are adjacent modulo 2*WIDTH. Index 5 → 0 is up; index 0 → 5 is down.
- **States.** The FSM has three states: UNLOCKED, LOCKED, ERROR.
- **UNLOCKED, valid legal code.** Load index and go to LOCKED. No step, no position change, up_down unchanged.
- **UNLOCKED, valid illegal code.** Pulse code_err and go to ERROR.
- **LOCKED, same index.** Hold all state. No pulse.
- **LOCKED, index+1.** Pulse step, set up_down = 0, position += 1, update index.
- **LOCKED, index−1.** Pulse step, set up_down = 1, position −= 1, update index.
- **LOCKED, legal non-adjacent code.** Pulse step_err, load the new index, stay in LOCKED. Position and up_down are unchanged.
- **LOCKED, illegal code.** Pulse code_err and go to ERROR. index holds its last legal value.
- **ERROR, legal code.** Load index and go to LOCKED with no step.
- **ERROR, illegal code.** Pulse code_err again and stay in ERROR.
- **in_valid = 0.** No state change, and all pulses are 0.
- **locked output.** locked = 1 exactly when the state is LOCKED.
- **Position arithmetic.** Two's-complement, wrapping silently: 0x7FFF + 1 = 0x8000 (POS_W = 16).
- **Mutual exclusion.** At most one of step, code_err, step_err is high in any cycle.

## Timing
- All outputs are registered.
  - Latency is one clock: a sample taken on edge N appears on the outputs after edge N.
  - Pulses last exactly one cycle.
- A new sample may be accepted every cycle. Back-to-back adjacent steps give consecutive step pulses.
- **Reset values** (reset low, asynchronous):
  - state = UNLOCKED
  - index = 0, up_down = 0, locked = 0
  - step = 0, code_err = 0, step_err = 0
  - position = 0
- Asserting reset mid-stream clears all outputs immediately, without waiting for a clock edge.
- The first valid sample after reset deassertion only locks; it never produces a step.

## Test plan
- **Reset and lock.** Hold reset low, then release. Apply in_valid = 1 with in = 000.
  - Required: all outputs 0 during reset.
  - One cycle after the sample: locked = 1, index = 0, step = 0, position = 0.
- **Up count with wrap.** Feed 000, 001, 011, 111, 110, 100, 000 on consecutive cycles.
  - Required: step pulses on 6 consecutive cycles, up_down = 0.
  - index sequence 1, 2, 3, 4, 5, 0; final position = 6.
- **Direction reversal.** Continuing from the up count, feed 100, 110.
  - Required: up_down = 1 on both steps, index 5 then 4, position returns to 4.
- **Illegal code and recovery.** While locked at 011, feed 010, then 101, then 111.
  - Required: code_err pulses on the first two samples, locked = 0, index holds 2.
  - On 111: locked = 1, index = 3, no step, position unchanged.
- **Non-adjacent jump, stall, and idle.** While locked at 000, feed 111.
  - Required: step_err pulse, index = 3, position unchanged.
  - Then repeat 111 and drop in_valid for 3 cycles: no pulses, outputs unchanged.
- **Position wrap and async reset.** Preload position to 0x7FFF by stepping up (or by force), then take one up step.
  - Required: position = 0x8000.
  - Then assert reset between clock edges: outputs clear immediately, before the next edge.
